// File: rtl/totient_sequencer.sv
// totient_sequencer: sweeps n over 1..N_MAX (wrap or ping-pong) and emits (n, phi(n)),
// where phi(n) counts k in 1..n with gcd(k,n)=1 using a subtractive GCD.
module totient_sequencer #(
   parameter int WIDTH = 5,
   parameter int N_MAX = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             mode,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_n,
   output logic [WIDTH-1:0] out_phi,
   output logic             busy,
   output logic             direction
);
   typedef enum logic [1:0] {IDLE, GCD, OUT} state_t;
   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
   localparam logic [WIDTH-1:0] NMAX = WIDTH'(N_MAX);
   state_t           state_q, state_d;
   logic [WIDTH-1:0] n_q, n_d, k_q, k_d, a_q, a_d, b_q, b_d, cnt_q, cnt_d, phi_q, phi_d;
   logic             dir_q, dir_d;
   logic [WIDTH-1:0] coprime;
   assign coprime   = {{(WIDTH-1){1'b0}}, a_q == ONE};
   assign out_valid = state_q == OUT;
   assign busy      = state_q == GCD;
   assign out_n     = n_q;
   assign out_phi   = phi_q;
   assign direction = dir_q;
   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      k_d     = k_q;
      a_d     = a_q;
      b_d     = b_q;
      cnt_d   = cnt_q;
      phi_d   = phi_q;
      dir_d   = dir_q;
      case (state_q)
         IDLE: if (enable) begin
            a_d     = n_q;
            b_d     = ONE;
            k_d     = ONE;
            cnt_d   = '0;
            state_d = GCD;
         end
         GCD: if (a_q > b_q) a_d = a_q - b_q;
         else if (a_q < b_q) b_d = b_q - a_q;
         else begin
            cnt_d = cnt_q + coprime;
            if (k_q == n_q) begin
               phi_d   = cnt_q + coprime;
               state_d = OUT;
            end else begin
               k_d = k_q + ONE;
               a_d = n_q;
               b_d = k_q + ONE;
            end
         end
         OUT: if (out_ready) begin
            state_d = IDLE;
            // wrap also clears a stale descending direction
            if (!mode) begin
               dir_d = 1'b0;
               n_d   = (n_q == NMAX) ? ONE : n_q + ONE;
            end else if (!dir_q) begin
               dir_d = n_q == NMAX;
               n_d   = (n_q == NMAX) ? NMAX - ONE : n_q + ONE;
            end else begin
               dir_d = n_q != ONE;
               n_d   = (n_q == ONE) ? WIDTH'(2) : n_q - ONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         n_q     <= ONE;
         k_q     <= ONE;
         a_q     <= '0;
         b_q     <= '0;
         cnt_q   <= '0;
         phi_q   <= '0;
         dir_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         k_q     <= k_d;
         a_q     <= a_d;
         b_q     <= b_d;
         cnt_q   <= cnt_d;
         phi_q   <= phi_d;
         dir_q   <= dir_d;
      end
   end
endmodule

// File: tb/tb_totient_sequencer.sv
// tb_totient_sequencer: random and directed stimulus checked every cycle against a
// behavioural phase/countdown model of the totient sweep.
module tb_totient_sequencer;
   localparam int WIDTH = 5;
   localparam int NM = 16;
   logic clock = 1'b0, reset = 1'b1, enable = 1'b0, mode = 1'b1, out_ready = 1'b1;
   logic out_valid, busy, direction;
   logic [WIDTH-1:0] out_n, out_phi;
   int errors = 0, checks = 0;
   int m_ph, m_rem, m_n, m_dir, m_phi;
   bit m_on = 0;
   int acc_n[$], acc_phi[$];
   int phi_tab[32] = '{1,1,2,2,4,2,6,4,6,4,10,4,12,6,8,8, 8,6,12,4,10,4,6,4,6,2,4,2,2,1,1, 1};

   totient_sequencer #(.WIDTH(WIDTH), .N_MAX(NM)) dut (
      .clock(clock), .reset(reset), .enable(enable), .mode(mode), .out_ready(out_ready),
      .out_valid(out_valid), .out_n(out_n), .out_phi(out_phi), .busy(busy), .direction(direction)
   );

   always #5 clock = ~clock;

   task automatic chk(string nm, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int phi_of(int n);
      int c = 0;
      for (int k = 1; k <= n; k++) begin
         int x = n, y = k, t;
         while (y != 0) begin t = x % y; x = y; y = t; end
         if (x == 1) c++;
      end
      return c;
   endfunction

   // number of GCD-state cycles: sum over k of (subtraction steps + 1)
   function automatic int gcd_cycles(int n);
      int tot = 0;
      for (int k = 1; k <= n; k++) begin
         int a = n, b = k, s = 0;
         while (a != b) begin
            if (a > b) a -= b; else b -= a;
            s++;
         end
         tot += s + 1;
      end
      return tot;
   endfunction

   always @(posedge clock) begin
      if (reset) begin
         m_ph <= 0; m_n <= 1; m_dir <= 0; m_phi <= 0; m_on <= 1;
      end else if (m_on) begin
         if (out_valid && out_ready) begin
            acc_n.push_back(int'(out_n));
            acc_phi.push_back(int'(out_phi));
         end
         case (m_ph)
            0: if (enable) begin m_ph <= 1; m_rem <= gcd_cycles(m_n); end
            1: if (m_rem == 1) begin m_ph <= 2; m_phi <= phi_of(m_n); end else m_rem <= m_rem - 1;
            default: if (out_ready) begin
               m_ph <= 0;
               if (!mode) begin m_dir <= 0; m_n <= m_n % NM + 1; end
               else if (m_dir == 0) begin
                  if (m_n == NM) begin m_dir <= 1; m_n <= NM - 1; end else m_n <= m_n + 1;
               end else begin
                  if (m_n == 1) begin m_dir <= 0; m_n <= 2; end else m_n <= m_n - 1;
               end
            end
         endcase
      end
   end

   always @(negedge clock) if (m_on) begin
      chk("valid", int'(out_valid), int'(m_ph == 2));
      chk("busy", int'(busy), int'(m_ph == 1));
      chk("n", int'(out_n), m_n);
      chk("dir", int'(direction), m_dir);
      if (m_ph == 2) chk("phi", int'(out_phi), m_phi);
   end

   task automatic wait_valid();
      int i = 0;
      while (!out_valid && i < 1000) begin @(negedge clock); i++; end
      if (!out_valid) chk("timeout_valid", 0, 1);
   endtask

   task automatic pulse();
      out_ready = 1'b1;
      @(negedge clock);
      out_ready = 1'b0;
   endtask

   task automatic step_to(int t);
      for (int i = 0; i < 40; i++) begin
         wait_valid();
         if (int'(out_n) == t) return;
         pulse();
      end
      chk("timeout_step", int'(out_n), t);
   endtask

   task automatic wait_acc(int sz);
      int i = 0;
      while (acc_n.size() < sz && i < 5000) begin @(negedge clock); i++; end
      if (acc_n.size() < sz) chk("timeout_acc", acc_n.size(), sz);
   endtask

   initial begin
      int lat;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_n", int'(out_n), 1);
      chk("rst_phi", int'(out_phi), 0);
      chk("rst_dir", int'(direction), 0);
      chk("rst_busy", int'(busy), 0);
      enable = 1'b1;
      lat = 0;
      do begin @(negedge clock); lat++; end while (!out_valid && lat < 100);
      chk("lat1", lat, 2);
      chk("lat1_n", int'(out_n), 1);
      chk("lat1_phi", int'(out_phi), 1);
      @(negedge clock);
      chk("idle_after_hs", int'(out_valid), 0);
      lat = 0;
      do begin @(negedge clock); lat++; end while (!out_valid && lat < 100);
      chk("lat2", lat, 4);
      chk("lat2_n", int'(out_n), 2);
      chk("lat2_phi", int'(out_phi), 1);
      wait_acc(16);
      chk("dir_after_16", int'(direction), 1);
      wait_acc(32);
      out_ready = 1'b0;
      for (int i = 0; i < 32 && i < acc_n.size(); i++) begin
         chk($sformatf("seq_n[%0d]", i), acc_n[i], i < 16 ? i + 1 : (i < 31 ? 31 - i : 2));
         chk($sformatf("seq_phi[%0d]", i), acc_phi[i], phi_tab[i]);
      end
      step_to(12);
      repeat (20) begin
         @(negedge clock);
         chk("bp_valid", int'(out_valid), 1);
         chk("bp_n", int'(out_n), 12);
         chk("bp_phi", int'(out_phi), 4);
      end
      pulse();
      wait_valid();
      chk("bp_next_n", int'(out_n), 13);
      mode = 1'b0;
      step_to(16);
      chk("wrap16_phi", int'(out_phi), 8);
      pulse();
      wait_valid();
      chk("wrap_n", int'(out_n), 1);
      chk("wrap_phi", int'(out_phi), 1);
      chk("wrap_dir", int'(direction), 0);
      mode = 1'b1;
      step_to(16);
      pulse();
      step_to(9);
      chk("desc9_dir", int'(direction), 1);
      mode = 1'b0;
      pulse();
      wait_valid();
      chk("switch_n", int'(out_n), 10);
      chk("switch_dir", int'(direction), 0);
      mode = 1'b1;
      step_to(14);
      pulse();
      repeat (3) @(negedge clock);
      chk("mid15_busy", int'(busy), 1);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk("post_rst_valid", int'(out_valid), 0);
      wait_valid();
      chk("post_rst_n", int'(out_n), 1);
      chk("post_rst_phi", int'(out_phi), 1);
      chk("post_rst_dir", int'(direction), 0);
      enable = 1'b0;
      pulse();
      repeat (30) begin
         @(negedge clock);
         chk("pause_valid", int'(out_valid), 0);
      end
      enable = 1'b1;
      lat = 0;
      while (!busy && lat < 10) begin @(negedge clock); lat++; end
      enable = 1'b0;
      wait_valid();
      chk("pause_done_n", int'(out_n), 2);
      chk("pause_done_phi", int'(out_phi), 1);
      for (int i = 0; i < 3000; i++) begin
         @(negedge clock);
         enable = $urandom_range(0, 7) != 0;
         out_ready = $urandom_range(0, 1) == 1;
         if ($urandom_range(0, 15) == 0) mode = $urandom_range(0, 1) == 1;
         reset = $urandom_range(0, 299) == 0;
      end
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
